// File: rtl/sample_window_stats.sv
// Per-window average/min/max of accepted samples over 2^LOG2_WIN-sample windows, valid/ready result port.
// Optional macro SAMPLE_WINDOW_ROUND_EN selects a round-half-up, saturated average instead of truncation.
module sample_window_stats #(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  input  logic              out_ready,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              out_valid,
  output logic              overrun
);

  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state;
  logic [SUM_W-1:0]    sum;
  logic [LOG2_WIN-1:0] cnt;
  logic [DATA_W-1:0]   run_min;
  logic [DATA_W-1:0]   run_max;

  logic                accept;
  logic [SUM_W-1:0]    sum_total;
  logic [DATA_W-1:0]   next_min;
  logic [DATA_W-1:0]   next_max;
  logic [DATA_W-1:0]   avg_next;

  assign accept    = en && sample_valid && (state == ACCUM);
  assign sum_total = sum + SUM_W'(sample_in);
  assign next_min  = (sample_in < run_min) ? sample_in : run_min;
  assign next_max  = (sample_in > run_max) ? sample_in : run_max;

`ifdef SAMPLE_WINDOW_ROUND_EN
  localparam logic [SUM_W:0] HALF = (SUM_W+1)'(1) << (LOG2_WIN - 1);

  logic [SUM_W:0] rounded;
  logic [SUM_W:0] rounded_shift;

  // One extra carry bit so the half-LSB bias cannot wrap before the shift.
  always_comb begin
    rounded       = {1'b0, sum_total} + HALF;
    rounded_shift = rounded >> LOG2_WIN;
    avg_next      = (|rounded_shift[SUM_W:DATA_W]) ? '1 : rounded_shift[DATA_W-1:0];
  end
`else
  always_comb begin
    avg_next = DATA_W'(sum_total >> LOG2_WIN);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cnt       <= '0;
      run_min   <= '1;
      run_max   <= '0;
      avg_out   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      state     <= ACCUM;
    end else if (clear) begin
      // Abort the window; the last published results stay visible.
      sum       <= '0;
      cnt       <= '0;
      run_min   <= '1;
      run_max   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      state     <= ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt == CNT_LAST) begin
              avg_out   <= avg_next;
              min_out   <= next_min;
              max_out   <= next_max;
              out_valid <= 1'b1;
              state     <= HOLD;
              sum       <= '0;
              cnt       <= '0;
              run_min   <= '1;
              run_max   <= '0;
            end else begin
              sum     <= sum_total;
              cnt     <= cnt + 1'b1;
              run_min <= next_min;
              run_max <= next_max;
            end
          end
        end
        HOLD: begin
          // Samples arriving while a result is pending are lost, including on the handshake cycle.
          if (en && sample_valid) overrun <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_window_stats.sv
// Directed bench for sample_window_stats: expected window results are queued by the stimulus
// and a negedge monitor pops and compares them on every output handshake.
module tb_sample_window_stats;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       clear;
  logic       out_ready;
  logic [7:0] avg_out;
  logic [7:0] min_out;
  logic [7:0] max_out;
  logic       out_valid;
  logic       overrun;

  typedef struct packed {
    logic [7:0] avg;
    logic [7:0] mn;
    logic [7:0] mx;
  } result_t;

  result_t expected_q[$];
  int checks = 0;
  int errors = 0;

`ifdef SAMPLE_WINDOW_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  sample_window_stats #(.DATA_W(8), .LOG2_WIN(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .out_ready    (out_ready),
    .avg_out      (avg_out),
    .min_out      (min_out),
    .max_out      (max_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d,
                               input logic clr, input logic rdy);
    en           = e;
    sample_valid = v;
    sample_in    = d;
    clear        = clr;
    out_ready    = rdy;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic sendSample(input logic [7:0] d, input logic rdy);
    applyStimulus(1'b1, 1'b1, d, 1'b0, rdy);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, rdy);
  endtask

  task automatic expectResult(input int a, input int mn, input int mx);
    result_t r;
    r.avg = 8'(a);
    r.mn  = 8'(mn);
    r.mx  = 8'(mx);
    expected_q.push_back(r);
  endtask

  // Monitor: every accepted result must match the next queued expectation.
  initial begin
    result_t r;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (expected_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got avg %0d min %0d max %0d, expected none",
                   avg_out, min_out, max_out);
        end else begin
          r = expected_q.pop_front();
          checkOutput("result_avg", avg_out, r.avg);
          checkOutput("result_min", min_out, r.mn);
          checkOutput("result_max", max_out, r.mx);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1'b1; en = 1'b0; sample_in = '0; sample_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_avg", avg_out, 0);
    checkOutput("reset_min", min_out, 0);
    checkOutput("reset_max", max_out, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_overrun", overrun, 0);
    rst = 1'b0;

    // Ramp 10..17, average 13.5
    expectResult(ROUND ? 14 : 13, 10, 17);
    for (int i = 10; i < 17; i++) begin
      sendSample(8'(i), 1'b1);
      checkOutput("ramp_no_early_valid", out_valid, 0);
    end
    sendSample(8'd17, 1'b1);
    checkOutput("ramp_latency_valid", out_valid, 1);
    checkOutput("ramp_overrun", overrun, 0);
    idle(1'b1);
    checkOutput("ramp_valid_dropped", out_valid, 0);

    // Full-scale samples must not wrap the sum
    expectResult(255, 255, 255);
    repeat (8) sendSample(8'd255, 1'b1);
    idle(1'b1);

    // Back-pressure: result held, extra samples dropped and flagged
    expectResult(ROUND ? 5 : 4, 1, 8);
    for (int i = 1; i <= 8; i++) sendSample(8'(i), 1'b0);
    repeat (3) sendSample(8'd99, 1'b0);
    checkOutput("hold_valid", out_valid, 1);
    checkOutput("hold_avg_stable", avg_out, ROUND ? 5 : 4);
    checkOutput("hold_max_stable", max_out, 8);
    checkOutput("hold_overrun", overrun, 1);
    idle(1'b1);
    checkOutput("hold_released", out_valid, 0);
    expectResult(40, 40, 40);
    repeat (8) sendSample(8'd40, 1'b1);
    idle(1'b1);
    checkOutput("overrun_sticky", overrun, 1);

    // Clear aborts a partial window; sample on the clear cycle is ignored
    repeat (5) sendSample(8'd200, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'd200, 1'b1, 1'b1);
    checkOutput("clear_overrun", overrun, 0);
    checkOutput("clear_keeps_avg", avg_out, 40);
    expectResult(100, 100, 100);
    repeat (8) sendSample(8'd100, 1'b1);
    idle(1'b1);
    checkOutput("clear_window_overrun", overrun, 0);

    // en=0 cycles with junk samples must be ignored
    expectResult(28, 0, 56);
    for (int i = 0; i < 8; i++) begin
      sendSample(8'(i * 8), 1'b1);
      if (i < 7) applyStimulus(1'b0, 1'b1, 8'd255, 1'b0, 1'b1);
    end
    idle(1'b1);

    // Reset mid-window discards the partial window and outputs
    repeat (4) sendSample(8'd77, 1'b1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    checkOutput("midrst_avg", avg_out, 0);
    checkOutput("midrst_min", min_out, 0);
    checkOutput("midrst_max", max_out, 0);
    checkOutput("midrst_valid", out_valid, 0);
    expectResult(50, 50, 50);
    repeat (8) sendSample(8'd50, 1'b1);
    idle(1'b1);

    wait_cycles = 0;
    while (expected_q.size() != 0 && wait_cycles < 20) begin
      idle(1'b1);
      wait_cycles++;
    end
    checkOutput("pending_results", expected_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
